// File: rtl/lifo_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack_pkg
// Description : Shared definitions for the LIFO stack. Holds the default
//               geometry, the count-width helper and the operation decode
//               that turns push/pop strobes plus stack status into a single
//               accepted operation.
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_stack_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 16;

   // Operation actually carried out this cycle. Rejected requests decode to
   // OP_NONE; the error flags are derived separately from the raw strobes.
   typedef enum logic [1:0] {
      OP_NONE    = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_REPLACE = 2'd3
   } op_t;

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A push+pop is always a replace-top (or a pass-through when empty).
   // A lone push while full is only accepted when circular overwrite is on.
   function automatic op_t decode_op(
      input logic push,
      input logic pop,
      input logic empty,
      input logic full,
      input logic wrap_en
   );
      op_t op;
      op = OP_NONE;
      if (push && pop) begin
         op = OP_REPLACE;
      end else if (push) begin
         op = (full && !wrap_en) ? OP_NONE : OP_PUSH;
      end else if (pop) begin
         op = empty ? OP_NONE : OP_POP;
      end
      return op;
   endfunction

endpackage : lifo_stack_pkg
`default_nettype wire

// File: rtl/lifo_stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack_mem
// Description : Entry storage for the LIFO stack. DATA_W x DEPTH register
//               array with one synchronous write port and one asynchronous
//               read port. Contents are not reset.
// Ports       : clk    - write clock
//               we     - write enable
//               waddr  - write index
//               wdata  - write data
//               raddr  - read index
//               rdata  - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule : lifo_stack_mem
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack
// Description : Parametrised LIFO stack (return-address / operand stack).
//               Combinational peek of the top entry, registered pop result
//               with a one-cycle valid strobe, same-cycle replace-top,
//               occupancy count and sticky overflow/underflow flags.
//               Optional build macro LIFO_STACK_WRAP_EN turns a push while
//               full into a circular overwrite of the oldest entry.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               push, push_data     - push request and its data
//               pop                 - pop request
//               err_clr             - clears the sticky error flags
//               top_data            - current top entry, 0 when empty
//               pop_data, pop_valid - registered pop result and its strobe
//               count, empty, full  - occupancy status
//               overflow, underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack
   import lifo_stack_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int CNT_W  = calc_cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   input  logic              err_clr,
   output logic [DATA_W-1:0] top_data,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   localparam int               c_IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
`ifdef LIFO_STACK_WRAP_EN
   localparam logic             c_WRAP_EN = 1'b1;
`else
   localparam logic             c_WRAP_EN = 1'b0;
`endif

   logic [CNT_W-1:0]  r_ptr;       // next free slot
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_pop_data;
   logic              r_pop_valid;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_empty;
   logic              w_full;
   op_t               w_op;
   logic [CNT_W-1:0]  w_top_idx;
   logic [CNT_W-1:0]  w_ptr_inc;
   logic              w_we;
   logic [CNT_W-1:0]  w_waddr;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_ovf_set;
   logic              w_unf_set;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_DEPTH);
   assign w_op    = decode_op(push, pop, w_empty, w_full, c_WRAP_EN);

   // Index of the top entry. The 0 -> DEPTH-1 wrap only matters in the
   // circular build; otherwise ptr is 0 only when empty and the read data is
   // masked off anyway.
   assign w_top_idx = (r_ptr == '0) ? c_LAST : (r_ptr - c_ONE);

`ifdef LIFO_STACK_WRAP_EN
   assign w_ptr_inc = (r_ptr == c_LAST) ? '0 : (r_ptr + c_ONE);
`else
   assign w_ptr_inc = r_ptr + c_ONE;
`endif

   // Push writes the free slot; replace-top overwrites the current top.
   // A replace on an empty stack is a pass-through and leaves memory alone.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_ptr;
      case (w_op)
         OP_PUSH: begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
         end
         OP_REPLACE: begin
            w_we    = !w_empty;
            w_waddr = w_top_idx;
         end
         default: begin
            w_we    = 1'b0;
            w_waddr = r_ptr;
         end
      endcase
   end

   lifo_stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (c_IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (w_we),
      .waddr (c_IDX_W'(w_waddr)),
      .wdata (push_data),
      .raddr (c_IDX_W'(w_top_idx)),
      .rdata (w_rd_data)
   );

   assign w_ovf_set = push && !pop && w_full;
   assign w_unf_set = pop && !push && w_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= '0;
         r_count     <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_pop_valid <= 1'b0;
         case (w_op)
            OP_PUSH: begin
               r_ptr <= w_ptr_inc;
               // A circular overwrite while full keeps the count at DEPTH.
               if (!w_full) begin
                  r_count <= r_count + c_ONE;
               end
            end
            OP_POP: begin
               r_pop_data  <= w_rd_data;
               r_pop_valid <= 1'b1;
               r_ptr       <= w_top_idx;
               r_count     <= r_count - c_ONE;
            end
            OP_REPLACE: begin
               r_pop_data  <= w_empty ? push_data : w_rd_data;
               r_pop_valid <= 1'b1;
            end
            default: begin
            end
         endcase
         // A set event in the same cycle as err_clr wins.
         r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
         r_underflow <= w_unf_set | (r_underflow & ~err_clr);
      end
   end

   assign top_data  = w_empty ? '0 : w_rd_data;
   assign pop_data  = r_pop_data;
   assign pop_valid = r_pop_valid;
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule : lifo_stack
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_stack
// Description : Self-checking bench for lifo_stack (DATA_W=8, DEPTH=4).
//               Table of per-cycle input/expected-output records plus a short
//               hand-written pop-strobe sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic [DW-1:0] push_data;
   logic          err_clr;
   logic [DW-1:0] top_data;
   logic [DW-1:0] pop_data;
   logic          pop_valid;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          underflow;

   always #5 clk = ~clk;

   lifo_stack #(
      .DATA_W (DW),
      .DEPTH  (DP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .err_clr   (err_clr),
      .top_data  (top_data),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   typedef struct {
      logic          rst;
      logic          psh;
      logic          pp;
      logic          clr;
      logic [DW-1:0] d;
      logic [CW-1:0] cnt;
      logic [DW-1:0] top;
      logic          pv;
      logic [DW-1:0] pd;
      logic          emp;
      logic          ful;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic rst, input logic psh, input logic pp,
                      input logic clr, input logic [DW-1:0] d,
                      input logic [CW-1:0] cnt, input logic [DW-1:0] top,
                      input logic pv, input logic [DW-1:0] pd,
                      input logic emp, input logic ful,
                      input logic ovf, input logic unf);
      vec_t v;
      v.rst = rst; v.psh = psh; v.pp = pp; v.clr = clr; v.d = d;
      v.cnt = cnt; v.top = top; v.pv = pv; v.pd = pd;
      v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int row,
                        input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;

      //   rst psh pop clr  data   cnt  top   pv  pd    emp ful ovf unf
      add(1, 0, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0A,  1, 8'h0A, 0, 8'h00, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0B,  2, 8'h0B, 0, 8'h00, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0C,  3, 8'h0C, 0, 8'h00, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0D,  4, 8'h0D, 0, 8'h00, 0, 1, 0, 0);
`ifdef LIFO_STACK_WRAP_EN
      // full push overwrites circularly; pops walk back over the wrap
      add(0, 1, 0, 0, 8'h0E,  4, 8'h0E, 0, 8'h00, 0, 1, 1, 0);
      add(0, 0, 1, 0, 8'h00,  3, 8'h0D, 1, 8'h0E, 0, 0, 1, 0);
      add(0, 0, 1, 0, 8'h00,  2, 8'h0C, 1, 8'h0D, 0, 0, 1, 0);
      add(0, 0, 1, 0, 8'h00,  1, 8'h0B, 1, 8'h0C, 0, 0, 1, 0);
      add(0, 0, 1, 0, 8'h00,  0, 8'h00, 1, 8'h0B, 1, 0, 1, 0);
`else
      // full push rejected; replace-top while full; err_clr drops overflow
      add(0, 1, 0, 0, 8'h0E,  4, 8'h0D, 0, 8'h00, 0, 1, 1, 0);
      add(0, 1, 1, 0, 8'h0F,  4, 8'h0F, 1, 8'h0D, 0, 1, 1, 0);
      add(0, 0, 0, 1, 8'h00,  4, 8'h0F, 0, 8'h0D, 0, 1, 0, 0);
`endif
      add(1, 0, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0A,  1, 8'h0A, 0, 8'h00, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0B,  2, 8'h0B, 0, 8'h00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00,  1, 8'h0A, 1, 8'h0B, 0, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00,  0, 8'h00, 1, 8'h0A, 1, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00,  0, 8'h00, 0, 8'h0A, 1, 0, 0, 1);
      add(0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 8'h0A, 1, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0A,  1, 8'h0A, 0, 8'h0A, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h0B,  2, 8'h0B, 0, 8'h0A, 0, 0, 0, 0);
      add(0, 1, 1, 0, 8'h55,  2, 8'h55, 1, 8'h0B, 0, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00,  2, 8'h55, 0, 8'h0B, 0, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00,  1, 8'h0A, 1, 8'h55, 0, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00,  0, 8'h00, 1, 8'h0A, 1, 0, 0, 0);
      add(0, 1, 1, 0, 8'h77,  0, 8'h00, 1, 8'h77, 1, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00,  0, 8'h00, 0, 8'h77, 1, 0, 0, 1);
      add(0, 0, 1, 1, 8'h00,  0, 8'h00, 0, 8'h77, 1, 0, 0, 1);
      add(0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 8'h77, 1, 0, 0, 0);
      add(0, 1, 0, 0, 8'h01,  1, 8'h01, 0, 8'h77, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h02,  2, 8'h02, 0, 8'h77, 0, 0, 0, 0);
      add(0, 1, 0, 0, 8'h03,  3, 8'h03, 0, 8'h77, 0, 0, 0, 0);
      add(1, 1, 0, 0, 8'h09,  0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00, 1, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset     = vecs[i].rst;
         push      = vecs[i].psh;
         pop       = vecs[i].pp;
         err_clr   = vecs[i].clr;
         push_data = vecs[i].d;
         @(posedge clk);
         #1;
         check("count",     i, 32'(count),     32'(vecs[i].cnt));
         check("top_data",  i, 32'(top_data),  32'(vecs[i].top));
         check("pop_valid", i, 32'(pop_valid), 32'(vecs[i].pv));
         check("pop_data",  i, 32'(pop_data),  32'(vecs[i].pd));
         check("empty",     i, 32'(empty),     32'(vecs[i].emp));
         check("full",      i, 32'(full),      32'(vecs[i].ful));
         check("overflow",  i, 32'(overflow),  32'(vecs[i].ovf));
         check("underflow", i, 32'(underflow), 32'(vecs[i].unf));
      end

      // pop strobe lasts exactly one cycle and pop_data holds afterwards
      reset = 1'b0; push = 1'b1; pop = 1'b0; err_clr = 1'b0; push_data = 8'h5A;
      @(posedge clk); #1;
      check("seq_top_after_push", 100, 32'(top_data), 32'h5A);
      push = 1'b0; pop = 1'b1;
      check("seq_top_same_cycle", 101, 32'(top_data), 32'h5A);
      @(posedge clk); #1;
      check("seq_pop_valid", 102, 32'(pop_valid), 32'h1);
      check("seq_pop_data",  103, 32'(pop_data),  32'h5A);
      pop = 1'b0;
      @(posedge clk); #1;
      check("seq_pop_valid_drop", 104, 32'(pop_valid), 32'h0);
      check("seq_pop_data_hold",  105, 32'(pop_data),  32'h5A);
      check("seq_empty",          106, 32'(empty),     32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_lifo_stack
`default_nettype wire
